row_scheduler: RTL

ROW_SCHEDULER -- requirements
Module: row_scheduler

---
 rtl/row_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/row_scheduler.sv
// Scrolling playfield row scheduler: a free-running scroll counter shifts a
// four-row field downward, refilled from a small FIFO fed by a request/ack generator.
module row_scheduler #(
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT   = 16,
  parameter logic [0:15] EMPTY_ROW = 16'b1000000110000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [26:0] scale,
  output logic        gen_req,
  input  logic        gen_ack,
  input  logic [0:15] gen_seq,
  output logic        scroll,
  output logic [0:63] field,
  output logic [4:0]  fifo_count,
  output logic [7:0]  underflow_cnt,
  output logic        gen_timeout
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             TW         = $clog2(TIMEOUT + 1);
  localparam logic [4:0]     DEPTH_C    = 5'(DEPTH);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t         state;
  logic [26:0]    scale_eff;
  logic [26:0]    scale_clamped;
  logic [31:0]    cnt;
  logic [31:0]    scale_ext;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [TW-1:0]  timer;
  logic [0:15]    mem [DEPTH];
  logic [0:15]    rows [4];
  logic           wrap;
  logic           trigger;
  logic           push;
  logic           pop;
  logic           fifo_empty;

  // A period shorter than two cycles would collapse request and wrap points.
  assign scale_clamped = (scale < 27'd2) ? 27'd2 : scale;
  assign scale_ext     = {5'd0, scale_eff};
  assign wrap          = run && (cnt == scale_ext - 32'd1);
  assign trigger       = (state == IDLE) && run && (cnt == (scale_ext >> 1))
                         && (fifo_count < DEPTH_C);
  assign fifo_empty    = (fifo_count == 5'd0);
  assign push          = (state == REQ) && gen_ack;
  assign pop           = wrap && !fifo_empty;
  assign field         = {rows[0], rows[1], rows[2], rows[3]};

  // NOTE: FIFO storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= gen_seq;
  end

  // NOTE: all state below updates with <= so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      scale_eff     <= scale_clamped;
      cnt           <= '0;
      state         <= IDLE;
      gen_req       <= 1'b0;
      timer         <= '0;
      gen_timeout   <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      underflow_cnt <= '0;
      scroll        <= 1'b0;
      for (int i = 0; i < 4; i++) rows[i] <= EMPTY_ROW;
    end else begin
      if (run) cnt <= wrap ? '0 : cnt + 32'd1;
      scroll <= wrap;

      if (wrap) begin
        scale_eff <= scale_clamped;
        rows[3]   <= rows[2];
        rows[2]   <= rows[1];
        rows[1]   <= rows[0];
        // An empty FIFO never bypasses a same-edge push into the field.
        rows[0]   <= fifo_empty ? EMPTY_ROW : mem[rd_ptr];
        if (fifo_empty && underflow_cnt != 8'hFF)
          underflow_cnt <= underflow_cnt + 8'd1;
      end

      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          if (trigger) begin
            state   <= REQ;
            gen_req <= 1'b1;
            timer   <= '0;
          end
        end
        REQ: begin
          if (gen_ack) begin
            state   <= IDLE;
            gen_req <= 1'b0;
            timer   <= '0;
          end else if (timer == TIMER_LAST) begin
            state       <= IDLE;
            gen_req     <= 1'b0;
            timer       <= '0;
            gen_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gen_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
